// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush control for a 5-stage pipeline (load-use, taken branch,
// data-memory wait with timeout) plus saturating stall/flush performance counters.
`default_nettype none

module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_memread,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic             err_clr,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             idex_stall,
  output logic             exmem_hold,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              mem_timeout_q, mem_timeout_d;
  logic [CNT_W-1:0]  stall_cnt_q, flush_cnt_q;

  logic lu, ms, hold, eval_run, flush_inc;

  assign lu = ex_memread && (ex_rd != 5'd0) &&
              ((id_uses_rs1 && (id_rs1 == ex_rd)) || (id_uses_rs2 && (id_rs2 == ex_rd)));
  assign ms = mem_req && !mem_ready;

  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    hold        = 1'b0;
    eval_run    = 1'b0;
    pc_we       = 1'b1;
    ifid_we     = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    idex_stall  = 1'b0;
    exmem_hold  = 1'b0;
    flush_inc   = 1'b0;

    case (state_q)
      RUN: begin
        if (ms) begin
          hold    = 1'b1;
          state_d = MEM_WAIT;
          wait_d  = '0;
        end else begin
          eval_run = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (!mem_ready) begin
          hold   = 1'b1;
          wait_d = wait_q + WAIT_W'(1);
          if (wait_q >= WAIT_LAST) state_d = ERROR;
        end else begin
          // Release cycle behaves exactly like RUN, so a held branch acts only here.
          eval_run = 1'b1;
          state_d  = RUN;
        end
      end
      ERROR: begin
        hold = 1'b1;
        if (err_clr) state_d = RUN;
      end
      default: state_d = RUN;
    endcase

    if (hold) begin
      pc_we      = 1'b0;
      ifid_we    = 1'b0;
      idex_stall = 1'b1;
      exmem_hold = 1'b1;
    end else if (eval_run && ex_branch_taken) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      flush_inc   = 1'b1;
    end else if (eval_run && lu) begin
      pc_we       = 1'b0;
      ifid_we     = 1'b0;
      idex_bubble = 1'b1;
    end

    // Keep the pipeline free-running while reset is asserted, whatever the inputs.
    if (!rstn) begin
      pc_we       = 1'b1;
      ifid_we     = 1'b1;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      idex_stall  = 1'b0;
      exmem_hold  = 1'b0;
      flush_inc   = 1'b0;
    end
  end

  assign mem_timeout_d = (state_d == ERROR);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= RUN;
      wait_q        <= '0;
      mem_timeout_q <= 1'b0;
      stall_cnt_q   <= '0;
      flush_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      wait_q        <= wait_d;
      mem_timeout_q <= mem_timeout_d;
      if (!pc_we && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (flush_inc && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign mem_timeout = mem_timeout_q;
  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed scoreboard bench for pipeline_hazard_ctrl
// (MEM_TIMEOUT=4, CNT_W=8 so timeout and counter saturation are reachable).
`default_nettype none

module tb_pipeline_hazard_ctrl;

  localparam int TMO = 4;
  localparam int CW  = 8;

  // Control vector order: {pc_we, ifid_we, ifid_flush, idex_bubble, idex_stall, exmem_hold, mem_timeout}
  localparam logic [6:0] C_RUN  = 7'b1100000;
  localparam logic [6:0] C_LU   = 7'b0001000;
  localparam logic [6:0] C_BR   = 7'b1111000;
  localparam logic [6:0] C_HOLD = 7'b0000110;
  localparam logic [6:0] C_ERR  = 7'b0000111;

  logic          clk = 1'b0;
  logic          rstn;
  logic [4:0]    id_rs1, id_rs2, ex_rd;
  logic          id_uses_rs1, id_uses_rs2, ex_memread, ex_branch_taken;
  logic          mem_req, mem_ready, err_clr;
  logic          pc_we, ifid_we, ifid_flush, idex_bubble, idex_stall, exmem_hold, mem_timeout;
  logic [CW-1:0] stall_cnt, flush_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    string      tag;
    logic [6:0] ctl;
    logic [7:0] sc;
    logic [7:0] fc;
  } exp_t;

  exp_t sbq[$];

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clk(clk), .rstn(rstn),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_memread(ex_memread), .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready), .err_clr(err_clr),
    .pc_we(pc_we), .ifid_we(ifid_we), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
    .idex_stall(idex_stall), .exmem_hold(exmem_hold), .mem_timeout(mem_timeout),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  task automatic idle();
    id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
    id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; ex_memread = 1'b0; ex_branch_taken = 1'b0;
    mem_req = 1'b0; mem_ready = 1'b0; err_clr = 1'b0;
  endtask

  task automatic expect_now(string tag, logic [6:0] ctl, int sc, int fc);
    sbq.push_back('{tag, ctl, sc[7:0], fc[7:0]});
  endtask

  task automatic check_out();
    exp_t e;
    logic [6:0] obs;
    if (sbq.size() == 0) begin
      n_cmp++;
      n_fail++;
      $error("FAIL sb_empty: observed output with no expected entry");
    end else begin
      e   = sbq.pop_front();
      obs = {pc_we, ifid_we, ifid_flush, idex_bubble, idex_stall, exmem_hold, mem_timeout};
      n_cmp++;
      assert (obs === e.ctl) else begin
        n_fail++;
        $error("FAIL %s ctl: observed %b expected %b", e.tag, obs, e.ctl);
      end
      n_cmp++;
      assert (stall_cnt === e.sc) else begin
        n_fail++;
        $error("FAIL %s stall_cnt: observed %0d expected %0d", e.tag, stall_cnt, e.sc);
      end
      n_cmp++;
      assert (flush_cnt === e.fc) else begin
        n_fail++;
        $error("FAIL %s flush_cnt: observed %0d expected %0d", e.tag, flush_cnt, e.fc);
      end
    end
  endtask

  // Inputs are set just after a rising edge; outputs are checked on the falling edge.
  task automatic cyc(string tag, logic [6:0] ctl, int sc, int fc);
    expect_now(tag, ctl, sc, fc);
    @(negedge clk);
    check_out();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstn = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1;

    // Hazards present during reset must not reach the outputs.
    mem_req = 1'b1; ex_branch_taken = 1'b1;
    cyc("reset_gate", C_RUN, 0, 0);
    idle();
    rstn = 1'b1;

    cyc("idle", C_RUN, 0, 0);

    ex_memread = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_uses_rs2 = 1'b1;
    cyc("lu_rs2", C_LU, 0, 0);
    idle();
    cyc("lu_after", C_RUN, 1, 0);

    ex_memread = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_uses_rs1 = 1'b1;
    cyc("lu_x0", C_RUN, 1, 0);

    ex_memread = 1'b1; ex_rd = 5'd9; id_rs2 = 5'd9; id_uses_rs2 = 1'b0;
    cyc("lu_unused", C_RUN, 1, 0);

    idle();
    ex_memread = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd7; id_uses_rs1 = 1'b1; ex_branch_taken = 1'b1;
    cyc("br_over_lu", C_BR, 1, 0);
    idle();
    cyc("br_after", C_RUN, 1, 1);

    // Fresh counters for the memory-wait release scenario.
    rstn = 1'b0;
    #1;
    expect_now("rst_clear", C_RUN, 0, 0);
    check_out();
    rstn = 1'b1;
    @(posedge clk);
    #1;

    mem_req = 1'b1; mem_ready = 1'b0; ex_branch_taken = 1'b1;
    cyc("ms_run", C_HOLD, 0, 0);
    cyc("ms_wait1", C_HOLD, 1, 0);
    cyc("ms_wait2", C_HOLD, 2, 0);
    mem_ready = 1'b1;
    cyc("ms_release_br", C_BR, 3, 0);
    idle();
    cyc("ms_after", C_RUN, 3, 1);

    // Timeout: RUN hold cycle, then four MEM_WAIT cycles, then ERROR.
    mem_req = 1'b1; mem_ready = 1'b0;
    cyc("to_run", C_HOLD, 3, 1);
    cyc("to_w1", C_HOLD, 4, 1);
    cyc("to_w2", C_HOLD, 5, 1);
    cyc("to_w3", C_HOLD, 6, 1);
    cyc("to_w4", C_HOLD, 7, 1);
    cyc("to_err", C_ERR, 8, 1);
    mem_ready = 1'b1;
    cyc("err_ready", C_ERR, 9, 1);
    mem_req = 1'b0; err_clr = 1'b1;
    cyc("err_clr", C_ERR, 10, 1);
    idle();
    cyc("err_exit", C_RUN, 11, 1);

    // Asynchronous reset in the middle of a memory wait.
    mem_req = 1'b1; mem_ready = 1'b0;
    cyc("mw_run", C_HOLD, 11, 1);
    cyc("mw_wait", C_HOLD, 12, 1);
    rstn = 1'b0;
    #1;
    expect_now("rst_mid_wait", C_RUN, 0, 0);
    check_out();
    idle();
    rstn = 1'b1;
    cyc("post_rst1", C_RUN, 0, 0);
    cyc("post_rst2", C_RUN, 0, 0);

    // Held load-use stalls every cycle; counter must stop at all-ones.
    ex_memread = 1'b1; ex_rd = 5'd3; id_rs1 = 5'd3; id_uses_rs1 = 1'b1;
    for (int i = 0; i < (1 << CW) + 5; i++) begin
      cyc("sat", C_LU, (i > 255) ? 255 : i, 0);
    end
    idle();
    cyc("sat_final", C_RUN, 255, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
